// File: rtl/mito_ofm_drain.sv
// mito_ofm_drain: captures completed accelerator output words into a circular FIFO and replays them as a valid/ready stream tagged with end-of-layer.
// Latency: a capture edge in cycle N presents m_valid in cycle N+1 when the FIFO was empty.
// Backpressure: m_ready low holds the head stable; the accelerator cannot stall, so a capture into a full FIFO is dropped and recorded in overflow.
//
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   ofm_word_in           accelerator output word
//   ofm_full_in           rising edge = new word to capture
//   finish_in             rising edge = end of layer
//   m_data/m_valid/m_ready/m_last   host stream (head of FIFO)
//   fifo_level            current occupancy
//   word_count            words captured in the current layer (saturating)
//   overflow              sticky, a capture was dropped
//   done                  one-cycle pulse once the layer's last word has drained
//
// Optional build macro MITO_OFM_DRAIN_PARITY_EN adds m_parity (per-entry XOR of
// the stored word) and parity_err_inject (inverts parity as it is stored).
// FIFO_DEPTH must be a power of two (pointers wrap naturally), at least 2.

module mito_ofm_drain #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_WIDTH-1:0]         ofm_word_in,
  input  logic                          ofm_full_in,
  input  logic                          finish_in,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          m_last,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_WIDTH-1:0]          word_count,
  output logic                          overflow,
`ifdef MITO_OFM_DRAIN_PARITY_EN
  output logic                          m_parity,
  input  logic                          parity_err_inject,
`endif
  output logic                          done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_FLUSH   = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  // Storage: data words, and per-entry end-of-layer tags kept in a separate
  // vector so a late finish can set the tag of an already-stored word.
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] tag_q;
`ifdef MITO_OFM_DRAIN_PARITY_EN
  logic [FIFO_DEPTH-1:0] par_q;
`endif

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] last_ptr;
  logic [LVL_W-1:0] level;
  logic [1:0]       state;
  logic [1:0]       state_nxt;

  logic ofm_full_q;
  logic finish_q;
  logic push;
  logic fin;
  logic pop;
  logic full;
  logic wr_en;
  logic drop;
  logic layer_fin;
  logic wr_tag;
  logic keep_tag;
  logic tag_set;

  // ---------------------------------------------------------------------------
  // Edge detection and handshake decode
  // ---------------------------------------------------------------------------
  always_comb begin
    push     = ofm_full_in & ~ofm_full_q;
    fin      = finish_in & ~finish_q;
    m_valid  = (level != '0);
    pop      = m_valid & m_ready;
    full     = (level == LVL_W'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    wr_en    = push & (~full | pop);
    drop     = push & full & ~pop;
    last_ptr = wr_ptr - PTR_W'(1);
  end

  // ---------------------------------------------------------------------------
  // End-of-layer tagging
  // ---------------------------------------------------------------------------
  // A finish closes a layer when one is open: either already collecting, or
  // idle with the layer's first word arriving in this same cycle.
  // If a word is written with the finish, that word carries the tag.
  // Otherwise the most recently stored word is tagged, provided it is still in
  // the FIFO after this cycle's pop; if it is leaving right now (or nothing is
  // stored) there is nothing left to tag and the layer completes immediately.
  always_comb begin
    layer_fin = fin & ((state == ST_COLLECT) | ((state == ST_IDLE) & push));
    wr_tag    = layer_fin & wr_en;
    keep_tag  = layer_fin & ~wr_en & (level > LVL_W'(pop));
    tag_set   = wr_tag | keep_tag;
  end

  // ---------------------------------------------------------------------------
  // Layer FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (push) begin
          if (layer_fin) state_nxt = tag_set ? ST_FLUSH : ST_DONE;
          else           state_nxt = ST_COLLECT;
        end else if (fin) begin
          // Empty layer: finish with nothing captured.
          state_nxt = ST_DONE;
        end
      end
      ST_COLLECT: begin
        if (layer_fin) state_nxt = tag_set ? ST_FLUSH : ST_DONE;
      end
      ST_FLUSH: begin
        if (pop && m_last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      ofm_full_q <= 1'b0;
      finish_q   <= 1'b0;
    end else begin
      state      <= state_nxt;
      ofm_full_q <= ofm_full_in;
      finish_q   <= finish_in;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO pointers, occupancy and tags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      tag_q  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr         <= wr_ptr + PTR_W'(1);
        tag_q[wr_ptr]  <= wr_tag;
      end
      // keep_tag implies no write this cycle, so the two never collide.
      if (keep_tag) begin
        tag_q[last_ptr] <= 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      level <= level + LVL_W'(wr_en) - LVL_W'(pop);
    end
  end

  // Data storage needs no reset: a slot is only visible after it is written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= ofm_word_in;
    end
  end

`ifdef MITO_OFM_DRAIN_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= '0;
    end else if (wr_en) begin
      par_q[wr_ptr] <= (^ofm_word_in) ^ parity_err_inject;
    end
  end

  assign m_parity = m_valid & par_q[rd_ptr];
`endif

  // ---------------------------------------------------------------------------
  // Per-layer word counter and overflow flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_count <= '0;
      overflow   <= 1'b0;
    end else begin
      overflow <= overflow | drop;
      if ((state == ST_IDLE) && push) begin
        // First word of a new layer restarts the count.
        word_count <= wr_en ? CNT_WIDTH'(1) : '0;
      end else if (wr_en && (word_count != '1)) begin
        word_count <= word_count + CNT_WIDTH'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Head outputs are forced to zero while empty so stale slots never show.
  assign m_data     = m_valid ? mem[rd_ptr] : '0;
  assign m_last     = m_valid & tag_q[rd_ptr];
  assign fifo_level = level;
  assign done       = (state == ST_DONE);

endmodule

// File: tb/tb_mito_ofm_drain.sv
// tb_mito_ofm_drain: directed bench for mito_ofm_drain with hand-computed expectations.
// Inputs are driven and outputs sampled at the falling clock edge.
// Each scenario starts from a fresh reset.

module tb_mito_ofm_drain;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int CW    = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] ofm_word_in = '0;
  logic          ofm_full_in = 1'b0;
  logic          finish_in = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          m_last;
  logic [LW-1:0] fifo_level;
  logic [CW-1:0] word_count;
  logic          overflow;
  logic          done;
`ifdef MITO_OFM_DRAIN_PARITY_EN
  logic          m_parity;
  logic          parity_err_inject = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;

  mito_ofm_drain #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ofm_word_in (ofm_word_in),
    .ofm_full_in (ofm_full_in),
    .finish_in   (finish_in),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_last      (m_last),
    .fifo_level  (fifo_level),
    .word_count  (word_count),
    .overflow    (overflow),
`ifdef MITO_OFM_DRAIN_PARITY_EN
    .m_parity         (m_parity),
    .parity_err_inject(parity_err_inject),
`endif
    .done        (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; ofm_full_in = 1'b0; finish_in = 1'b0; m_ready = 1'b0; ofm_word_in = '0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ofm_full_in = 1'b0; finish_in = 1'b0; m_ready = 1'b0;
    tick(); tick();
    n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
    n_vec++; if (m_data !== '0) begin n_err++; $display("FAIL reset_m_data: got %h want 0", m_data); end
    n_vec++; if (m_last !== 1'b0) begin n_err++; $display("FAIL reset_m_last: got %b want 0", m_last); end
    n_vec++; if (fifo_level !== '0) begin n_err++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    n_vec++; if (word_count !== '0) begin n_err++; $display("FAIL reset_word_count: got %0d want 0", word_count); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    rst_n = 1'b1;
  endtask

  task automatic test_single_word();
    apply_reset();
    m_ready = 1'b1; ofm_word_in = 32'h0000_00A5; ofm_full_in = 1'b1;
    tick();
    n_vec++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", m_valid); end
    n_vec++; if (m_data !== 32'h0000_00A5) begin n_err++; $display("FAIL single_data: got %h want 000000a5", m_data); end
    n_vec++; if (m_last !== 1'b0) begin n_err++; $display("FAIL single_last: got %b want 0", m_last); end
    ofm_full_in = 1'b0;
    tick();
    n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL single_drained_valid: got %b want 0", m_valid); end
    n_vec++; if (fifo_level !== '0) begin n_err++; $display("FAIL single_level: got %0d want 0", fifo_level); end
    n_vec++; if (word_count !== 16'd1) begin n_err++; $display("FAIL single_word_count: got %0d want 1", word_count); end
  endtask

  task automatic test_level_hold();
    apply_reset();
    m_ready = 1'b0; ofm_full_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ofm_word_in = 32'h1111 + i;
      tick();
    end
    ofm_full_in = 1'b0;
    n_vec++; if (fifo_level !== 5'd1) begin n_err++; $display("FAIL hold_level: got %0d want 1", fifo_level); end
    n_vec++; if (word_count !== 16'd1) begin n_err++; $display("FAIL hold_word_count: got %0d want 1", word_count); end
    n_vec++; if (m_data !== 32'h0000_1111) begin n_err++; $display("FAIL hold_data: got %h want 00001111", m_data); end
    m_ready = 1'b1;
    tick();
    n_vec++; if (fifo_level !== '0) begin n_err++; $display("FAIL hold_drain_level: got %0d want 0", fifo_level); end
  endtask

  task automatic test_overflow();
    apply_reset();
    m_ready = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      ofm_word_in = i; ofm_full_in = 1'b1;
      tick();
      ofm_full_in = 1'b0;
      tick();
    end
    n_vec++; if (fifo_level !== 5'd16) begin n_err++; $display("FAIL ovf_level: got %0d want 16", fifo_level); end
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    n_vec++; if (word_count !== 16'd16) begin n_err++; $display("FAIL ovf_word_count: got %0d want 16", word_count); end
    m_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      n_vec++;
      if (m_valid !== 1'b1 || m_data !== 32'(i)) begin
        n_err++; $display("FAIL ovf_beat%0d: got valid=%b data=%h want valid=1 data=%h", i, m_valid, m_data, 32'(i));
      end
      tick();
    end
    n_vec++; if (m_valid !== 1'b0 || fifo_level !== '0) begin n_err++; $display("FAIL ovf_empty: got valid=%b level=%0d want 0/0", m_valid, fifo_level); end
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_last_tag();
    logic [DW-1:0] words [3];
    words[0] = 32'h100; words[1] = 32'h200; words[2] = 32'h300;
    apply_reset();
    m_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ofm_word_in = words[k]; ofm_full_in = 1'b1; finish_in = (k == 2);
      tick();
      n_vec++;
      if (m_valid !== 1'b1 || m_data !== words[k] || m_last !== (k == 2)) begin
        n_err++; $display("FAIL last_beat%0d: got valid=%b data=%h last=%b want 1/%h/%b", k, m_valid, m_data, m_last, words[k], (k == 2));
      end
      ofm_full_in = 1'b0; finish_in = 1'b0;
      tick();
      n_vec++;
      if (done !== (k == 2)) begin n_err++; $display("FAIL last_done%0d: got %b want %b", k, done, (k == 2)); end
    end
    n_vec++; if (word_count !== 16'd3) begin n_err++; $display("FAIL last_word_count: got %0d want 3", word_count); end
    tick();
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL last_done_width: got %b want 0", done); end
    // Back in IDLE: a new word restarts the count at 1.
    ofm_word_in = 32'h400; ofm_full_in = 1'b1;
    tick();
    ofm_full_in = 1'b0;
    n_vec++; if (word_count !== 16'd1) begin n_err++; $display("FAIL last_new_layer_count: got %0d want 1", word_count); end
    tick();
  endtask

  task automatic test_late_tag();
    apply_reset();
    m_ready = 1'b0; ofm_word_in = 32'h55; ofm_full_in = 1'b1;
    tick();
    ofm_full_in = 1'b0;
    tick();
    n_vec++; if (m_valid !== 1'b1 || m_last !== 1'b0) begin n_err++; $display("FAIL late_before: got valid=%b last=%b want 1/0", m_valid, m_last); end
    finish_in = 1'b1;
    tick();
    n_vec++;
    if (m_valid !== 1'b1 || m_last !== 1'b1 || m_data !== 32'h55) begin
      n_err++; $display("FAIL late_after: got valid=%b last=%b data=%h want 1/1/00000055", m_valid, m_last, m_data);
    end
    finish_in = 1'b0; m_ready = 1'b1;
    tick();
    n_vec++; if (done !== 1'b1 || m_valid !== 1'b0) begin n_err++; $display("FAIL late_done: got done=%b valid=%b want 1/0", done, m_valid); end
    tick();
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL late_done_width: got %b want 0", done); end
  endtask

  task automatic test_empty_layer();
    int seen_at;
    int pulses;
    bit valid_seen;
    seen_at = -1; pulses = 0; valid_seen = 1'b0;
    apply_reset();
    m_ready = 1'b1; finish_in = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      finish_in = 1'b0;
      if (done === 1'b1) begin
        pulses++;
        if (seen_at < 0) seen_at = c;
      end
      if (m_valid !== 1'b0) valid_seen = 1'b1;
    end
    n_vec++; if (seen_at < 0 || seen_at > 1) begin n_err++; $display("FAIL empty_done_time: got cycle %0d want 0..1", seen_at); end
    n_vec++; if (pulses != 1) begin n_err++; $display("FAIL empty_done_pulses: got %0d want 1", pulses); end
    n_vec++; if (valid_seen) begin n_err++; $display("FAIL empty_valid: got asserted want never"); end
  endtask

  task automatic test_reset_mid_layer();
    apply_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ofm_word_in = 32'hC0 + i; ofm_full_in = 1'b1;
      tick();
      ofm_full_in = 1'b0;
      tick();
    end
    n_vec++; if (fifo_level !== 5'd4) begin n_err++; $display("FAIL mid_level_before: got %0d want 4", fifo_level); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %b want 0", m_valid); end
    n_vec++; if (fifo_level !== '0) begin n_err++; $display("FAIL mid_level: got %0d want 0", fifo_level); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL mid_overflow: got %b want 0", overflow); end
    n_vec++; if (word_count !== '0) begin n_err++; $display("FAIL mid_word_count: got %0d want 0", word_count); end
    tick();
    rst_n = 1'b1;
    tick();
    n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL mid_after_release: got %b want 0", m_valid); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_level_hold();
    test_overflow();
    test_last_tag();
    test_late_tag();
    test_empty_layer();
    test_reset_mid_layer();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
